uart_xbee_rx: RTL

UART_XBEE_RX -- requirements
Module: uart_xbee_rx

---
 rtl/uart_xbee_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_xbee_rx.sv
// 8N1 UART receiver for the XBee link. Received bytes are paired into
// 16-bit words; an idle gap or a framing error abandons a half-built word.
module uart_xbee_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] word_data,
  output logic        word_valid
);

  localparam int CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          phase;
  logic [7:0]    low_byte;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      phase      <= 1'b0;
      low_byte   <= '0;
      gap_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      word_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else if (phase) begin
            // A long quiet line means the partner byte is never coming.
            if (gap_cnt == GAP_LAST) begin
              phase   <= 1'b0;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end else begin
            gap_cnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state    <= IDLE;
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (phase) begin
                word_data  <= {shreg, low_byte};
                word_valid <= 1'b1;
                phase      <= 1'b0;
              end else begin
                low_byte <= shreg;
                phase    <= 1'b1;
              end
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
              phase     <= 1'b0;
              low_byte  <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
